ula_serial_controller: RTL and testbench

- Multi-cycle sequencer that runs wide (N_BYTES x 8-bit) ADD, SUB, AND and OR operations on the team's 8-bit ALU datapath (ripple adder, AND and OR lanes), one byte per clock, LSB first.
- Carry is chained between bytes through a register.
- Sits between a requester (valid/ready command interface) and a consumer (valid/ready result interface).
- The 8-bit datapath lanes are instantiated inside this block.

---
 rtl/ula_serial_controller.sv | 271 +++++++++++++++++++++++++++
 tb/tb_ula_serial_controller.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ula_serial_controller.sv
// ---------------------------------------------------------------------------
// ula_serial_controller
//   Byte-serial sequencer for wide ADD / SUB / AND / OR operations. Operands
//   of N_BYTES bytes are processed LSB first, one byte per clock, on an 8-bit
//   datapath (ripple adder plus AND and OR lanes). The carry is chained
//   between bytes through a register.
//
// Ports
//   CLK        in   clock, rising edge
//   RST        in   asynchronous reset, active high
//   START      in   command valid
//   READY      out  command ready (high only while idle)
//   OP         in   opcode: 00 ADD, 01 SUB, 10 AND, 11 OR
//   A, B       in   W-bit operands (W = 8*N_BYTES)
//   RESULT     out  registered W-bit result
//   COUT       out  final carry for ADD/SUB (1 = no borrow on SUB), 0 otherwise
//   ZERO       out  RESULT == 0
//   RES_VALID  out  result valid (high only while holding a finished result)
//   RES_READY  in   consumer accepts the result
// ---------------------------------------------------------------------------

// 8-bit ripple-carry adder lane built from full-adder equations.
module ula_adder8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] sum_o,
  output logic       cout_o
);

  logic [8:0] carry_s;

  assign carry_s[0] = cin_i;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi = gi + 1) begin : g_fa
      assign sum_o[gi]       = a_i[gi] ^ b_i[gi] ^ carry_s[gi];
      assign carry_s[gi + 1] = (a_i[gi] & b_i[gi]) | (carry_s[gi] & (a_i[gi] ^ b_i[gi]));
    end
  endgenerate

  assign cout_o = carry_s[8];

endmodule

// 8-bit bitwise logic lanes (AND and OR), full width on every bit.
module ula_logic8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] and_o,
  output logic [7:0] or_o
);

  assign and_o = a_i & b_i;
  assign or_o  = a_i | b_i;

endmodule

module ula_serial_controller #(
  parameter int N_BYTES = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   START,
  output logic                   READY,
  input  logic [1:0]             OP,
  input  logic [8*N_BYTES-1:0]   A,
  input  logic [8*N_BYTES-1:0]   B,
  output logic [8*N_BYTES-1:0]   RESULT,
  output logic                   COUT,
  output logic                   ZERO,
  output logic                   RES_VALID,
  input  logic                   RES_READY
);

  localparam int W     = 8 * N_BYTES;
  localparam int IDX_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Registers and their next-state values
  state_t             state_q,  state_d;
  logic [W-1:0]       a_q,      a_d;
  logic [W-1:0]       b_q,      b_d;
  logic [1:0]         op_q,     op_d;
  logic [IDX_W-1:0]   idx_q,    idx_d;
  logic               carry_q,  carry_d;
  logic [W-1:0]       result_q, result_d;
  logic               cout_q,   cout_d;
  logic               zero_q,   zero_d;

  // Byte-lane datapath signals
  logic [7:0]         a_byte_s;
  logic [7:0]         b_raw_s;
  logic [7:0]         b_byte_s;
  logic [7:0]         sum_s;
  logic               add_cout_s;
  logic [7:0]         and_s;
  logic [7:0]         or_s;
  logic [7:0]         byte_s;
  logic               is_arith_s;
  logic [W-1:0]       assembled_s;

  // Byte offset of the current lane within the wide operands.
  logic [IDX_W+2:0]   bit_ofs_s;
  assign bit_ofs_s = {idx_q, 3'b000};

  // Select the current operand bytes; SUB feeds the inverted B byte so that
  // A - B = A + ~B + 1 with the +1 coming from the initial carry.
  always_comb begin
    a_byte_s = a_q[bit_ofs_s +: 8];
    b_raw_s  = b_q[bit_ofs_s +: 8];
    if (op_q == OP_SUB) begin
      b_byte_s = ~b_raw_s;
    end else begin
      b_byte_s = b_raw_s;
    end
  end

  ula_adder8 u_adder (
    .a_i    (a_byte_s),
    .b_i    (b_byte_s),
    .cin_i  (carry_q),
    .sum_o  (sum_s),
    .cout_o (add_cout_s)
  );

  ula_logic8 u_logic (
    .a_i    (a_byte_s),
    .b_i    (b_byte_s),
    .and_o  (and_s),
    .or_o   (or_s)
  );

  // Pick the lane output for the current opcode.
  always_comb begin
    byte_s     = sum_s;
    is_arith_s = 1'b1;
    case (op_q)
      OP_ADD: begin
        byte_s     = sum_s;
        is_arith_s = 1'b1;
      end
      OP_SUB: begin
        byte_s     = sum_s;
        is_arith_s = 1'b1;
      end
      OP_AND: begin
        byte_s     = and_s;
        is_arith_s = 1'b0;
      end
      OP_OR: begin
        byte_s     = or_s;
        is_arith_s = 1'b0;
      end
      default: begin
        byte_s     = sum_s;
        is_arith_s = 1'b1;
      end
    endcase
  end

  // Result with the current byte merged in; earlier bytes come from the
  // register, so on the last byte this is the complete W-bit value.
  always_comb begin
    assembled_s                = result_q;
    assembled_s[bit_ofs_s +: 8] = byte_s;
  end

  // Next-state and register update logic for the sequencer.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          a_d     = A;
          b_d     = B;
          op_d    = OP;
          idx_d   = '0;
          carry_d = (OP == OP_SUB);
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_EXEC: begin
        result_d = assembled_s;
        if (is_arith_s) begin
          carry_d = add_cout_s;
        end else begin
          carry_d = carry_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          cout_d  = is_arith_s & add_cout_s;
          zero_d  = (assembled_s == '0);
        end else begin
          idx_d   = idx_q + IDX_ONE;
        end
      end

      ST_DONE: begin
        if (RES_READY) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 2'b00;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
    end
  end

  // Handshake flags are decoded straight from the state register.
  assign READY     = (state_q == ST_IDLE);
  assign RES_VALID = (state_q == ST_DONE);
  assign RESULT    = result_q;
  assign COUT      = cout_q;
  assign ZERO      = zero_q;

endmodule

// File: tb/tb_ula_serial_controller.sv
// ---------------------------------------------------------------------------
// tb_ula_serial_controller
//   Self-checking bench for ula_serial_controller (N_BYTES = 4). Expected
//   results come from a reference model and travel through a scoreboard
//   queue from command issue to result delivery.
// ---------------------------------------------------------------------------
module tb_ula_serial_controller;

  localparam int N_BYTES = 4;
  localparam int W       = 8 * N_BYTES;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         z;
  } exp_t;

  logic         CLK;
  logic         RST;
  logic         START;
  logic         READY;
  logic [1:0]   OP;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] RESULT;
  logic         COUT;
  logic         ZERO;
  logic         RES_VALID;
  logic         RES_READY;

  int   total_cnt;
  int   bad_cnt;
  exp_t sb_q[$];

  ula_serial_controller #(.N_BYTES(N_BYTES)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .READY     (READY),
    .OP        (OP),
    .A         (A),
    .B         (B),
    .RESULT    (RESULT),
    .COUT      (COUT),
    .ZERO      (ZERO),
    .RES_VALID (RES_VALID),
    .RES_READY (RES_READY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain wide arithmetic, independent of the byte loop.
  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t         e;
    logic [W:0]   t;
    t = '0;
    case (op)
      2'b00: t = {1'b0, a} + {1'b0, b};
      2'b01: t = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
      2'b10: t = {1'b0, a & b};
      default: t = {1'b0, a | b};
    endcase
    e.res = t[W-1:0];
    e.c   = t[W];
    e.z   = (t[W-1:0] == '0);
    return e;
  endfunction

  // Issue one command, wait for the result, compare against the scoreboard,
  // optionally hold the result for 'hold' cycles while poking START.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit poke_exec, input int hold);
    exp_t e;
    int   cycles;
    sb_q.push_back(model(op, a, b));
    @(negedge CLK);
    OP = op; A = a; B = b; START = 1'b1;
    check_val("ready_idle", READY, 1);
    @(negedge CLK);
    START  = 1'b0;
    cycles = 0;
    while (RES_VALID !== 1'b1 && cycles < 64) begin
      @(negedge CLK);
      cycles++;
      if (poke_exec && RES_VALID !== 1'b1) begin
        START = 1'b1; A = ~a; B = ~b; OP = ~op;
        check_val("ready_exec", READY, 0);
      end
    end
    check_val("latency", cycles, N_BYTES);
    e = sb_q.pop_front();
    check_val("result", RESULT, e.res);
    check_val("cout", COUT, e.c);
    check_val("zero", ZERO, e.z);
    for (int i = 0; i < hold; i++) begin
      START = 1'b1; A = a ^ 32'h5A5A_5A5A; B = b ^ 32'hA5A5_A5A5; OP = op ^ 2'b10;
      @(negedge CLK);
      check_val("hold_valid", RES_VALID, 1);
      check_val("hold_ready", READY, 0);
      check_val("hold_result", RESULT, e.res);
      check_val("hold_cout", COUT, e.c);
      check_val("hold_zero", ZERO, e.z);
    end
    START     = 1'b0;
    RES_READY = 1'b1;
    @(negedge CLK);
    RES_READY = 1'b0;
    check_val("ready_after", READY, 1);
    check_val("valid_after", RES_VALID, 0);
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    RST       = 1'b1;
    START     = 1'b0;
    OP        = 2'b00;
    A         = '0;
    B         = '0;
    RES_READY = 1'b0;
    #1;
    check_val("rst_result", RESULT, 0);
    check_val("rst_cout", COUT, 0);
    check_val("rst_zero", ZERO, 0);
    check_val("rst_valid", RES_VALID, 0);
    check_val("rst_ready", READY, 1);
    @(negedge CLK);
    RST = 1'b0;

    // Basic arithmetic
    run_op(2'b00, 32'h0000_00FF, 32'h0000_0001, 1'b0, 0);
    run_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
    run_op(2'b01, 32'h0000_0005, 32'h0000_0005, 1'b0, 0);
    run_op(2'b01, 32'h0000_0003, 32'h0000_0005, 1'b0, 0);
    run_op(2'b01, 32'h8000_0000, 32'h0000_0001, 1'b0, 0);
    // Logic lanes
    run_op(2'b10, 32'hF0F0_1234, 32'hFFFF_00FF, 1'b0, 0);
    run_op(2'b10, 32'h0000_0010, 32'h0000_0000, 1'b0, 0);
    run_op(2'b11, 32'h1234_0000, 32'h0000_5678, 1'b0, 0);
    run_op(2'b11, 32'h0000_0000, 32'h0000_0000, 1'b0, 0);
    // Handshake: START poked during EXEC and DONE, result held 3 cycles
    run_op(2'b00, 32'h1357_9BDF, 32'h2468_ACE0, 1'b1, 3);

    // Reset in the middle of EXEC at byte index 2
    @(negedge CLK);
    OP = 2'b00; A = 32'h1111_1111; B = 32'h2222_2222; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check_val("mid_ready", READY, 0);
    RST = 1'b1;
    #1;
    check_val("abort_result", RESULT, 0);
    check_val("abort_cout", COUT, 0);
    check_val("abort_zero", ZERO, 0);
    check_val("abort_valid", RES_VALID, 0);
    check_val("abort_ready", READY, 1);
    @(negedge CLK);
    RST = 1'b0;
    run_op(2'b00, 32'h0001_0000, 32'h0001_0000, 1'b0, 0);

    // A few random commands
    for (int i = 0; i < 8; i++) begin
      run_op(2'($urandom_range(0, 3)), W'($urandom), W'($urandom), 1'b0, i % 2);
    end

    check_val("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
